// File: rtl/gpu_command_arbiter.sv
// gpu_command_arbiter: shares the single GPU command/data port between the
// host command path and the layer-header updater, one command in flight.
// Ports:
//   gpuClk, rst            clock, asynchronous active-low reset
//   gpuBusyController      GPU controller busy (1 = busy)
//   frameRendering         blocks every new grant while high
//   host*/upd*             valid/lock/command/data in, ready out (comb)
//   gpuCommand/gpuData     registered command/data to the GPU
//   gpuCmdValid            one-cycle issue strobe
//   grantOwner             00 none, 01 host, 10 updater
//   arbBusy, cmdTimeout    not idle; sticky wait-timeout flag
module gpu_command_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_UPD_STREAK = 4
) (
   input  logic        gpuClk,
   input  logic        rst,
   input  logic        gpuBusyController,
   input  logic        frameRendering,
   input  logic        hostValid,
   input  logic        hostLock,
   input  logic [15:0] hostCommand,
   input  logic [15:0] hostData,
   output logic        hostReady,
   input  logic        updValid,
   input  logic        updLock,
   input  logic [15:0] updCommand,
   input  logic [15:0] updData,
   output logic        updReady,
   output logic [15:0] gpuCommand,
   output logic [15:0] gpuData,
   output logic        gpuCmdValid,
   output logic [1:0]  grantOwner,
   output logic        arbBusy,
   output logic        cmdTimeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(MAX_UPD_STREAK + 1);

   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_UPD_STREAK);

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_HOST = 2'b01;
   localparam logic [1:0] OWN_UPD  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [15:0]   cmd_q;
   logic [15:0]   cmd_d;
   logic [15:0]   data_q;
   logic [15:0]   data_d;
   logic          cmd_valid_q;
   logic          cmd_valid_d;
   logic [1:0]    owner_q;
   logic [1:0]    owner_d;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;
   logic [TW-1:0] tmo_cnt_q;
   logic [TW-1:0] tmo_cnt_d;
   logic          timeout_q;
   logic          timeout_d;

   logic any_valid;
   logic host_wins;
   logic wait_first;
   logic tmo_hit;
   logic owner_lock;
   logic owner_valid;
   logic burst_ok;
   logic host_rdy;
   logic upd_rdy;

   // Request-side qualifiers.
   always_comb begin
      any_valid   = hostValid | updValid;
      // Updater wins unless it has starved a waiting host long enough.
      host_wins   = hostValid &
                    (~updValid | (streak_q == STREAK_MAX));
      // Counter holds the number of completed WAIT cycles.
      wait_first  = (tmo_cnt_q == '0);
      tmo_hit     = (tmo_cnt_q == TMO_LAST);
      owner_lock  = 1'b0;
      owner_valid = 1'b0;
      unique case (1'b1)
         (owner_q == OWN_HOST): begin
            owner_lock  = hostLock;
            owner_valid = hostValid;
         end
         (owner_q == OWN_UPD): begin
            owner_lock  = updLock;
            owner_valid = updValid;
         end
         default: begin
            owner_lock  = 1'b0;
            owner_valid = 1'b0;
         end
      endcase
      burst_ok = owner_lock & owner_valid & ~frameRendering;
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      data_d    = data_q;
      owner_d   = owner_q;
      streak_d  = streak_q;
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;
      host_rdy  = 1'b0;
      upd_rdy   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!frameRendering && any_valid) begin
               host_rdy = host_wins;
               upd_rdy  = ~host_wins;
            end
         end
         S_ISSUE: begin
            state_d   = S_WAIT;
            tmo_cnt_d = '0;
         end
         S_WAIT: begin
            if (tmo_cnt_q != TMO_MAX) begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            // Busy dropping beats a coincident timeout.
            if (!wait_first && !gpuBusyController) begin
               if (burst_ok) begin
                  host_rdy = (owner_q == OWN_HOST);
                  upd_rdy  = (owner_q == OWN_UPD);
               end else begin
                  state_d = S_IDLE;
                  owner_d = OWN_NONE;
               end
            end else if (tmo_hit && gpuBusyController) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
               owner_d   = OWN_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      if (host_rdy) begin
         state_d  = S_ISSUE;
         cmd_d    = hostCommand;
         data_d   = hostData;
         owner_d  = OWN_HOST;
         streak_d = '0;
      end else if (upd_rdy) begin
         state_d = S_ISSUE;
         cmd_d   = updCommand;
         data_d  = updData;
         owner_d = OWN_UPD;
         // Only contested IDLE grants starve the host.
         if (state_q == S_IDLE && hostValid &&
             streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
         end
      end

      cmd_valid_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge gpuClk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         data_q      <= '0;
         cmd_valid_q <= 1'b0;
         owner_q     <= OWN_NONE;
         streak_q    <= '0;
         tmo_cnt_q   <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         cmd_valid_q <= cmd_valid_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         tmo_cnt_q   <= tmo_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign hostReady   = host_rdy;
   assign updReady    = upd_rdy;
   assign gpuCommand  = cmd_q;
   assign gpuData     = data_q;
   assign gpuCmdValid = cmd_valid_q;
   assign grantOwner  = owner_q;
   assign arbBusy     = (state_q != S_IDLE);
   assign cmdTimeout  = timeout_q;

endmodule

// File: tb/tb_gpu_command_arbiter.sv
// tb_gpu_command_arbiter: directed and random stimulus for the GPU
// command arbiter, checked every cycle against a timeline model.
module tb_gpu_command_arbiter;

   localparam int TMO  = 16;
   localparam int MAXS = 4;

   logic        gpuClk = 1'b0;
   logic        rst = 1'b1;
   logic        gpuBusyController = 1'b0;
   logic        frameRendering = 1'b0;
   logic        hostValid = 1'b0;
   logic        hostLock = 1'b0;
   logic [15:0] hostCommand = '0;
   logic [15:0] hostData = '0;
   logic        hostReady;
   logic        updValid = 1'b0;
   logic        updLock = 1'b0;
   logic [15:0] updCommand = '0;
   logic [15:0] updData = '0;
   logic        updReady;
   logic [15:0] gpuCommand;
   logic [15:0] gpuData;
   logic        gpuCmdValid;
   logic [1:0]  grantOwner;
   logic        arbBusy;
   logic        cmdTimeout;

   gpu_command_arbiter #(
      .TIMEOUT_CYCLES(TMO),
      .MAX_UPD_STREAK(MAXS)
   ) dut (
      .gpuClk(gpuClk),
      .rst(rst),
      .gpuBusyController(gpuBusyController),
      .frameRendering(frameRendering),
      .hostValid(hostValid),
      .hostLock(hostLock),
      .hostCommand(hostCommand),
      .hostData(hostData),
      .hostReady(hostReady),
      .updValid(updValid),
      .updLock(updLock),
      .updCommand(updCommand),
      .updData(updData),
      .updReady(updReady),
      .gpuCommand(gpuCommand),
      .gpuData(gpuData),
      .gpuCmdValid(gpuCmdValid),
      .grantOwner(grantOwner),
      .arbBusy(arbBusy),
      .cmdTimeout(cmdTimeout)
   );

   always #5 gpuClk = ~gpuClk;

   int checks = 0;
   int errors = 0;

   // Model: a command in flight is described by who owns it and the
   // cycle its strobe appears; everything else follows from the age.
   int          cyc = 0;
   bit          m_inflight = 0;
   int          m_issue_t = 0;
   int          m_owner = 0;
   int          m_streak = 0;
   bit          m_tmo = 0;
   logic [15:0] m_cmd = '0;
   logic [15:0] m_data = '0;
   bit          e_hr = 0;
   bit          e_ur = 0;

   int seen_own[$];
   int seen_t[$];

   int p_hv, p_uv, p_drop, p_lock, p_busy, p_fr;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit gh, gu, fin, tmo;
      int age;
      gh  = 0;
      gu  = 0;
      fin = 0;
      tmo = 0;
      if (!m_inflight) begin
         if (!frameRendering && (hostValid || updValid)) begin
            if (hostValid && (!updValid || m_streak == MAXS)) gh = 1;
            else gu = 1;
         end
      end else begin
         age = cyc - m_issue_t;
         if (age >= 2 && !gpuBusyController) begin
            if (!frameRendering && m_owner == 1 && hostLock && hostValid)
               gh = 1;
            else if (!frameRendering && m_owner == 2 && updLock && updValid)
               gu = 1;
            else
               fin = 1;
         end else if (age == TMO && gpuBusyController) begin
            tmo = 1;
         end
      end
      e_hr = gh;
      e_ur = gu;

      chk("hostReady", 32'(hostReady), 32'(gh));
      chk("updReady", 32'(updReady), 32'(gu));
      chk("gpuCmdValid", 32'(gpuCmdValid),
          32'(m_inflight && cyc == m_issue_t));
      chk("gpuCommand", 32'(gpuCommand), 32'(m_cmd));
      chk("gpuData", 32'(gpuData), 32'(m_data));
      chk("grantOwner", 32'(grantOwner), 32'(m_inflight ? m_owner : 0));
      chk("arbBusy", 32'(arbBusy), 32'(m_inflight));
      chk("cmdTimeout", 32'(cmdTimeout), 32'(m_tmo));

      if (gpuCmdValid) begin
         seen_own.push_back(int'(grantOwner));
         seen_t.push_back(cyc);
      end

      if (gh) begin
         m_streak = 0;
         m_cmd    = hostCommand;
         m_data   = hostData;
         m_owner  = 1;
      end else if (gu) begin
         if (!m_inflight && hostValid && m_streak < MAXS) m_streak++;
         m_cmd   = updCommand;
         m_data  = updData;
         m_owner = 2;
      end
      if (gh || gu) begin
         m_inflight = 1;
         m_issue_t  = cyc + 1;
      end else if (fin || tmo) begin
         m_inflight = 0;
      end
      if (tmo) m_tmo = 1;
      cyc++;
   endtask

   task automatic tick();
      @(negedge gpuClk);
   endtask

   task automatic eval();
      #1;
      step();
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      frameRendering = 1'b1;
      #1;
      m_inflight = 0;
      m_streak   = 0;
      m_tmo      = 0;
      m_cmd      = '0;
      m_data     = '0;
      e_hr       = 0;
      e_ur       = 0;
      chk("rst_hostReady", 32'(hostReady), 32'd0);
      chk("rst_updReady", 32'(updReady), 32'd0);
      chk("rst_gpuCmdValid", 32'(gpuCmdValid), 32'd0);
      chk("rst_gpuCommand", 32'(gpuCommand), 32'd0);
      chk("rst_gpuData", 32'(gpuData), 32'd0);
      chk("rst_grantOwner", 32'(grantOwner), 32'd0);
      chk("rst_arbBusy", 32'(arbBusy), 32'd0);
      chk("rst_cmdTimeout", 32'(cmdTimeout), 32'd0);
      @(negedge gpuClk);
      hostValid         = 1'b0;
      updValid          = 1'b0;
      hostLock          = 1'b0;
      updLock           = 1'b0;
      frameRendering    = 1'b0;
      gpuBusyController = 1'b0;
      rst               = 1'b1;
   endtask

   task automatic drive();
      if (e_hr || !hostValid) begin
         hostValid   = (int'($urandom_range(99)) < p_hv);
         hostCommand = 16'($urandom);
         hostData    = 16'($urandom);
      end else if (int'($urandom_range(99)) < p_drop) begin
         hostValid = 1'b0;
      end
      if (e_ur || !updValid) begin
         updValid   = (int'($urandom_range(99)) < p_uv);
         updCommand = 16'($urandom);
         updData    = 16'($urandom);
      end else if (int'($urandom_range(99)) < p_drop) begin
         updValid = 1'b0;
      end
      hostLock = (int'($urandom_range(99)) < p_lock);
      updLock  = (int'($urandom_range(99)) < p_lock);
      gpuBusyController = (int'($urandom_range(99)) < p_busy);
      if (int'($urandom_range(99)) < p_fr) frameRendering = ~frameRendering;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      int nh, t_issue;
      bit ud;

      // Reset with every input active.
      hostValid = 1; updValid = 1; hostLock = 1; updLock = 1;
      gpuBusyController = 1; frameRendering = 1;
      hostCommand = 16'hFFFF; hostData = 16'hFFFF;
      updCommand = 16'hFFFF; updData = 16'hFFFF;
      do_reset();

      // Single host command.
      tick();
      hostValid = 1; hostCommand = 16'h8801; hostData = 16'h1234;
      eval();
      chk("t1_accept", 32'(hostReady), 32'd1);
      tick();
      hostValid = 0;
      eval();
      chk("t1_strobe", 32'(gpuCmdValid), 32'd1);
      chk("t1_cmd", 32'(gpuCommand), 32'h8801);
      chk("t1_data", 32'(gpuData), 32'h1234);
      chk("t1_owner", 32'(grantOwner), 32'd1);
      repeat (4) begin tick(); eval(); end

      // Contested grants: updater streak then forced host grant.
      seen_own.delete(); seen_t.delete();
      for (int i = 0; i < 44; i++) begin
         tick();
         if (e_hr || !hostValid) begin
            hostValid = 1; hostCommand = 16'($urandom);
            hostData = 16'($urandom);
         end
         if (e_ur || !updValid) begin
            updValid = 1; updCommand = 16'($urandom);
            updData = 16'($urandom);
         end
         eval();
      end
      for (int i = 0; i < 10; i++)
         chk($sformatf("order%0d", i),
             (i < seen_own.size()) ? 32'(seen_own[i]) : 32'hFF,
             32'(exp_order[i]));
      tick(); hostValid = 0; updValid = 0; eval();
      repeat (6) begin tick(); eval(); end

      // Locked host burst of 8 with the updater waiting.
      seen_own.delete(); seen_t.delete();
      nh = 0; ud = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (e_hr) begin
            nh++;
            hostData = 16'(nh);
            if (nh == 8) begin hostValid = 0; hostLock = 0; end
         end
         if (e_ur) begin ud = 1; updValid = 0; end
         if (i == 0) begin
            hostValid = 1; hostLock = 1;
            hostCommand = 16'h9000; hostData = 16'h0000;
            updValid = 0; updLock = 0;
            updCommand = 16'h5A5A; updData = 16'h0BEE;
         end else if (i == 1) begin
            updValid = 1;
         end
         eval();
      end
      chk("burst_updater_done", 32'(ud), 32'd1);
      for (int i = 0; i < 9; i++)
         chk($sformatf("burst_own%0d", i),
             (i < seen_own.size()) ? 32'(seen_own[i]) : 32'hFF,
             (i < 8) ? 32'd1 : 32'd2);
      for (int i = 1; i < 8; i++)
         chk($sformatf("burst_gap%0d", i),
             (i < seen_t.size()) ? 32'(seen_t[i] - seen_t[i-1]) : 32'hFF,
             32'd3);

      // Reset during the WAIT of a locked burst.
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 0) begin
            hostValid = 1; hostLock = 1;
            hostCommand = 16'h9001; hostData = 16'h7777;
         end
         eval();
      end
      chk("pre_rst_wait", 32'(arbBusy), 32'd1);
      do_reset();
      seen_own.delete(); seen_t.delete();
      repeat (8) begin tick(); eval(); end
      chk("rst_burst_no_issue", 32'(seen_t.size()), 32'd0);

      // Frame render blackout.
      for (int i = 0; i < 10; i++) begin
         tick();
         frameRendering = 1;
         if (i == 0) begin
            hostValid = 1; hostCommand = 16'h1111; hostData = 16'h2222;
            updValid = 1; updCommand = 16'h3333; updData = 16'h4444;
         end
         eval();
      end
      chk("fr_blocked", 32'(seen_t.size()), 32'd0);
      tick(); frameRendering = 0; eval();
      chk("fr_upd_first", 32'(updReady), 32'd1);
      tick(); hostValid = 0; updValid = 0; eval();
      repeat (6) begin tick(); eval(); end

      // Busy stuck high: timeout after TMO WAIT cycles.
      do_reset();
      tick();
      hostValid = 1; hostCommand = 16'hC0DE; hostData = 16'h0001;
      gpuBusyController = 1;
      eval();
      tick(); hostValid = 0; eval();
      t_issue = cyc - 1;
      repeat (TMO) begin tick(); eval(); end
      chk("tmo_not_yet", 32'(cmdTimeout), 32'd0);
      chk("tmo_age", 32'(cyc - 1 - t_issue), 32'(TMO));
      tick();
      hostValid = 1; hostCommand = 16'hBEEF; hostData = 16'h0002;
      gpuBusyController = 0;
      eval();
      chk("tmo_set", 32'(cmdTimeout), 32'd1);
      chk("tmo_idle", 32'(arbBusy), 32'd0);
      chk("tmo_next_accept", 32'(hostReady), 32'd1);
      tick(); hostValid = 0; eval();
      repeat (10) begin tick(); eval(); end
      chk("tmo_sticky", 32'(cmdTimeout), 32'd1);

      // Random traffic.
      for (int s = 0; s < 8; s++) begin
         if (s % 3 == 0) do_reset();
         p_hv   = int'($urandom_range(100, 20));
         p_uv   = int'($urandom_range(100, 20));
         p_drop = int'($urandom_range(20, 0));
         p_lock = int'($urandom_range(80, 0));
         p_fr   = int'($urandom_range(4, 0));
         case (s % 4)
            0: p_busy = 0;
            1: p_busy = 40;
            2: p_busy = 80;
            default: p_busy = 97;
         endcase
         for (int i = 0; i < 500; i++) begin
            tick();
            drive();
            eval();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/gpu_command_arbiter.md
# gpu_command_arbiter

Arbitrates the single GPU command/data port between two requesters: the host command path (from the command buffer) and the layer-header updater that injects header read/write commands after each frame render. It enforces one command in flight, honours the GPU controller busy signal and frame-render blackout, and supports locked bursts for block RAM/Flash transfers. It sits between the command buffer/header updater and the GPU memory controller, all on gpuClk.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles in WAIT before abort (counter width clog2(TIMEOUT_CYCLES+1)).
- MAX_UPD_STREAK, 4: consecutive contested updater grants before host is forced a grant.

- gpuClk  in  1  GPU clock; sole clock.
- rst  in  1  asynchronous, active-low reset.
- gpuBusyController  in  1  GPU controller busy, 1 = busy.
- frameRendering  in  1  frame render in progress; blocks all new grants.
- hostValid / updValid  in  1  request present; command/data held stable until ready.
- hostLock / updLock  in  1  keep grant for next command (burst).
- hostCommand / updCommand  in  16  command word.
- hostData / updData  in  16  data word.
- hostReady / updReady  out  1  combinational accept strobe; transfer = valid & ready.
- gpuCommand  out  16  registered command to GPU.
- gpuData  out  16  registered data to GPU.
- gpuCmdValid  out  1  one-cycle issue strobe.
- grantOwner  out  2  00 none, 01 host, 10 updater.
- arbBusy  out  1  1 when state != IDLE.
- cmdTimeout  out  1  sticky timeout flag.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if frameRendering=0 and a valid exists, pick winner, assert its ready, latch command/data/owner at edge -> ISSUE. Otherwise stay, no ready.
- Priority: updater > host, except when streak counter == MAX_UPD_STREAK and hostValid=1 -> host wins; counter clears on any host grant.
- Streak counter increments on an updater grant in IDLE while hostValid=1; locked continuation grants do not count; saturates at MAX_UPD_STREAK.
- ISSUE: gpuCmdValid=1 one cycle, -> WAIT; timeout counter cleared.
- WAIT: first cycle ignores gpuBusyController. Later cycles: busy=0 -> exit. On exit: if owner's lock=1, owner valid=1 and frameRendering=0, assert owner ready, latch, -> ISSUE (burst continuation, no arbitration); else -> IDLE, grantOwner=00.
- Lock is honoured only at WAIT exit; lock with valid=0 releases grant.
- Timeout: counter increments each WAIT cycle; reaching TIMEOUT_CYCLES with busy still 1 -> cmdTimeout=1 (sticky), -> IDLE, lock dropped.
- gpuCommand/gpuData hold last issued values until next latch.

## Timing
- Reset (rst=0, async): state IDLE, gpuCommand=0, gpuData=0, gpuCmdValid=0, grantOwner=00, arbBusy=0, cmdTimeout=0, counters 0; in-flight command discarded.
- Accept at cycle N (IDLE) -> gpuCmdValid in N+1 -> WAIT from N+2.
- Busy=0 throughout: IDLE re-entered N+4; unlocked back-to-back issue period 4 cycles; locked burst period 3 cycles.
- frameRendering rising during WAIT: current command completes; continuation and new grants deferred until frameRendering=0.
- Both valid same cycle: at most one ready high; never both.
- Valid dropped before ready: no transfer, no state change.
- Timeout and busy falling same cycle: busy=0 wins, no timeout.

## Test plan
- Reset with all inputs active -> all outputs 0; after release hostValid=1, cmd 0x8801, data 0x1234, busy=0 -> hostReady in accept cycle, gpuCmdValid next cycle with 0x8801/0x1234, grantOwner=01.
- hostValid and updValid held continuously, busy=0 -> grant order upd,upd,upd,upd,host,upd... (MAX_UPD_STREAK=4).
- hostLock=1, 8 host writes to RAM cmd 0x9000, updValid=1 throughout -> 8 consecutive host issues, 3-cycle spacing, updater granted only after lock drops.
- frameRendering=1 with both valids -> no ready, no gpuCmdValid; falling edge -> updater granted first.
- busy stuck 1 after issue, TIMEOUT_CYCLES=16 -> cmdTimeout=1 after 16 WAIT cycles, IDLE, next request accepted; flag stays until reset.
- rst asserted during WAIT of locked burst -> immediate IDLE, grantOwner=00, no further gpuCmdValid until new request.
